// File: rtl/sw_pkg.sv
// Purpose: shared constants for the slide-switch mode conditioning path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, default debounce length and the one-hot
// mode codes that the downstream LED pattern block decodes.
package sw_pkg;

    // Debounce FSM state encoding.
    typedef enum logic {
        ST_SETTLED  = 1'b0,
        ST_COUNTING = 1'b1
    } sw_state_t;

    // 20 ms at a 50 MHz CLK.
    localparam int DB_CYCLES_DEFAULT = 1000000;

    // Legal mode vectors as seen by the pattern block.
    localparam logic [3:0] MODE_FIXED = 4'b0001;
    localparam logic [3:0] MODE_ROT_L = 4'b0010;
    localparam logic [3:0] MODE_ROT_R = 4'b0100;
    localparam logic [3:0] MODE_ALT   = 4'b1000;

endpackage

// File: rtl/sw_sync.sv
// Purpose: WIDTH-bit multi-flop synchroniser for asynchronous switch inputs.
// Latency: STAGES CLK edges from d to q.
// Backpressure: none; free-running shift every cycle.
// Ports: CLK, RST_N (async active-low), d (async input bus), q (synchronised bus).
// Nothing sits between stages, so every flop after the first has a full cycle
// to resolve metastability. STAGES must be at least 2.
module sw_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [STAGES];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < STAGES; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/sw_debounce_mode.sv
// Purpose: synchronise and debounce the raw slide-switch bus into a clean mode vector.
// Latency: SYNC_STAGES + DB_CYCLES + 1 CLK edges from a stable SW_RAW change to SW_OUT.
// Backpressure: none; SW_CHANGED is a single-cycle strobe with no handshake.
// Ports: CLK, RST_N (async active-low); SW_RAW raw switches; SW_OUT committed
// mode; SW_CHANGED one-cycle pulse on commit; SW_ONEHOT registered mode status.
// Build option: define SW_ONEHOT_FILTER_EN to force non-one-hot candidates to
// commit as all-zero; SW_ONEHOT then reports whether any mode is selected.
module sw_debounce_mode
    import sw_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int CNT_W       = 24
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] SW_RAW,
    output logic [WIDTH-1:0] SW_OUT,
    output logic             SW_CHANGED,
    output logic             SW_ONEHOT
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sw_s;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;
    sw_state_t        state;

    logic [WIDTH-1:0] commit_val;
    logic             commit_oh;

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    sw_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (SW_RAW),
        .q     (sw_s)
    );

    // Value that a commit would write, and its status flag.
    always_comb begin
        commit_val = cand;
        commit_oh  = 1'b0;
`ifdef SW_ONEHOT_FILTER_EN
        if (!is_onehot(cand)) begin
            commit_val = '0;
        end
        commit_oh = |commit_val;
`else
        commit_oh = is_onehot(cand);
`endif
    end

    // The whole vector is debounced as one unit: any change of the
    // synchronised bus restarts the count, so skewed multi-bit edges
    // collapse into a single commit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_SETTLED;
            cand       <= '0;
            cnt        <= '0;
            SW_OUT     <= '0;
            SW_CHANGED <= 1'b0;
            SW_ONEHOT  <= 1'b0;
        end else begin
            SW_CHANGED <= 1'b0;
            case (state)
                ST_SETTLED: begin
                    if (sw_s != SW_OUT) begin
                        cand  <= sw_s;
                        cnt   <= '0;
                        state <= ST_COUNTING;
                    end
                end
                ST_COUNTING: begin
                    if (sw_s == SW_OUT) begin
                        // Glitch settled back to the committed value.
                        cnt   <= '0;
                        state <= ST_SETTLED;
                    end else if (sw_s != cand) begin
                        cand <= sw_s;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        SW_OUT     <= commit_val;
                        SW_ONEHOT  <= commit_oh;
                        // With filtering a rejected candidate may map onto the
                        // current value; that is not a visible change.
                        SW_CHANGED <= (commit_val != SW_OUT);
                        cnt        <= '0;
                        state      <= ST_SETTLED;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_SETTLED;
                end
            endcase
        end
    end

endmodule
